pd_sequencer: RTL and testbench

Power-domain sequencer that is the responder end of the activity monitor's power-gating request. It turns a level request (`pwr_req`) into an ordered clock-gate / isolate / retain / switch sequence and acknowledges completion on `pwr_ack`. It sits between the power-gating decision logic and one switchable domain, such as the ALU. It also keeps power statistics (off-cycle and wake counts) and a sticky switch-timeout error.

---
 rtl/pd_sequencer_if.sv | 28 ++
 rtl/pd_sequencer.sv | 131 +++++++++++++
 tb/tb_pd_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pd_sequencer_if.sv
// Request/acknowledge, switch feedback and status bundle between the power-gating
// controller (master) and the pd_sequencer (slave).
interface pd_sequencer_if;
  logic        pwr_req;
  logic        sw_ok;
  logic        pwr_ack;
  logic        clk_en;
  logic        iso_en;
  logic        sw_en;
  logic        ret_save;
  logic        ret_restore;
  logic        err;
  logic [3:0]  state;
  logic [31:0] off_cycles;
  logic [15:0] wake_cnt;

  modport master (
    output pwr_req, sw_ok,
    input  pwr_ack, clk_en, iso_en, sw_en, ret_save, ret_restore, err, state,
           off_cycles, wake_cnt
  );

  modport slave (
    input  pwr_req, sw_ok,
    output pwr_ack, clk_en, iso_en, sw_en, ret_save, ret_restore, err, state,
           off_cycles, wake_cnt
  );
endinterface

// File: rtl/pd_sequencer.sv
// Power-domain sequencer: clock-gate / isolate / retain / switch ordering with stats.
// Define PD_RETENTION_EN to include the OFF_SAVE / ON_RESTORE retention steps.
//
// state      | meaning
// ON         | domain powered, clock running, request acknowledged
// OFF_CLK    | clock gated
// OFF_ISO    | clamps on, settling for ISO_DLY cycles
// OFF_SAVE   | retention save pulse
// OFF_SW     | switch opened, waiting for rail collapse
// OFF        | domain off
// ON_SW      | switch closed, waiting for power-good
// ON_RESTORE | retention restore pulse
// ON_ISO     | clamps released, clock still gated, ISO_DLY cycles
module pd_sequencer #(
  parameter int unsigned ISO_DLY = 2,
  parameter int unsigned SW_DLY  = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  pd_sequencer_if.slave  if_pd
);

  typedef enum logic [3:0] {
    ST_ON         = 4'd0,
    ST_OFF_CLK    = 4'd1,
    ST_OFF_ISO    = 4'd2,
    ST_OFF_SAVE   = 4'd3,
    ST_OFF_SW     = 4'd4,
    ST_OFF        = 4'd5,
    ST_ON_SW      = 4'd6,
    ST_ON_RESTORE = 4'd7,
    ST_ON_ISO     = 4'd8
  } state_t;

  localparam logic [15:0] ISO_LAST = 16'(ISO_DLY - 1);
  localparam logic [15:0] SW_LAST  = 16'(SW_DLY - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

`ifdef PD_RETENTION_EN
  localparam state_t ST_AFTER_ISO = ST_OFF_SAVE;
  localparam state_t ST_AFTER_SW  = ST_ON_RESTORE;
`else
  localparam state_t ST_AFTER_ISO = ST_OFF_SW;
  localparam state_t ST_AFTER_SW  = ST_ON_ISO;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_timer;
  logic        r_err;
  logic [31:0] r_off_cycles;
  logic [15:0] r_wake_cnt;
  logic        w_iso_done;
  logic        w_sw_min;
  logic        w_timeout;
  logic        w_to_err;

  assign w_iso_done = (r_timer >= ISO_LAST);
  assign w_sw_min   = (r_timer >= SW_LAST);
  assign w_timeout  = (r_timer >= TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_to_err    = 1'b0;
    case (r_state)
      ST_ON:         if (!if_pd.pwr_req) w_state_nxt = ST_OFF_CLK;
      ST_OFF_CLK:    w_state_nxt = ST_OFF_ISO;
      ST_OFF_ISO:    if (w_iso_done) w_state_nxt = ST_AFTER_ISO;
      ST_OFF_SAVE:   w_state_nxt = ST_OFF_SW;
      ST_OFF_SW: begin
        if (!if_pd.sw_ok) begin
          w_state_nxt = ST_OFF;
        end else if (w_timeout) begin
          w_state_nxt = ST_OFF;
          w_to_err    = 1'b1;
        end
      end
      ST_OFF:        if (if_pd.pwr_req) w_state_nxt = ST_ON_SW;
      ST_ON_SW: begin
        // A good rail is only trusted once the minimum switch time has elapsed.
        if (w_sw_min && if_pd.sw_ok) begin
          w_state_nxt = ST_AFTER_SW;
        end else if (w_timeout) begin
          w_state_nxt = ST_AFTER_SW;
          w_to_err    = 1'b1;
        end
      end
      ST_ON_RESTORE: w_state_nxt = ST_ON_ISO;
      ST_ON_ISO:     if (w_iso_done) w_state_nxt = ST_ON;
      default:       w_state_nxt = ST_ON;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_ON;
      r_timer      <= '0;
      r_err        <= 1'b0;
      r_off_cycles <= '0;
      r_wake_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= (w_state_nxt != r_state) ? 16'd0 : r_timer + 16'd1;
      r_err   <= r_err | w_to_err;
      if (r_state == ST_OFF && r_off_cycles != 32'hFFFF_FFFF)
        r_off_cycles <= r_off_cycles + 32'd1;
      if (r_state == ST_ON_ISO && w_state_nxt == ST_ON)
        r_wake_cnt <= r_wake_cnt + 16'd1;
    end
  end

  assign if_pd.pwr_ack    = (r_state == ST_ON);
  assign if_pd.clk_en     = (r_state == ST_ON);
  assign if_pd.iso_en     = (r_state == ST_OFF_ISO) || (r_state == ST_OFF_SAVE) ||
                            (r_state == ST_OFF_SW)  || (r_state == ST_OFF)      ||
                            (r_state == ST_ON_SW)   || (r_state == ST_ON_RESTORE);
  assign if_pd.sw_en      = !((r_state == ST_OFF_SW) || (r_state == ST_OFF));
`ifdef PD_RETENTION_EN
  assign if_pd.ret_save    = (r_state == ST_OFF_SAVE);
  assign if_pd.ret_restore = (r_state == ST_ON_RESTORE);
`else
  assign if_pd.ret_save    = 1'b0;
  assign if_pd.ret_restore = 1'b0;
`endif
  assign if_pd.err        = r_err;
  assign if_pd.state      = r_state;
  assign if_pd.off_cycles = r_off_cycles;
  assign if_pd.wake_cnt   = r_wake_cnt;

endmodule

// File: tb/tb_pd_sequencer.sv
// Directed bench for pd_sequencer with default parameters; expectations follow
// whether PD_RETENTION_EN is defined for the build.
module tb_pd_sequencer;

`ifdef PD_RETENTION_EN
  localparam int RET = 1;
`else
  localparam int RET = 0;
`endif
  localparam int DN_N = 5 + RET;
  localparam int UP_N = 7 + RET;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_force = 1'b0;
  logic sw_val = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  // {state, pwr_ack, clk_en, iso_en, sw_en, ret_save, ret_restore} after each edge
  logic [9:0] dn_tab [DN_N];
  logic [9:0] up_tab [UP_N];

  pd_sequencer_if u_if ();

  assign u_if.sw_ok = sw_force ? sw_val : u_if.sw_en;

  pd_sequencer u_dut (
    .clk   (clk),
    .rst   (rst),
    .if_pd (u_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (u_if.state !== s && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, 32'(u_if.state), 32'(s));
  endtask

  function automatic logic [9:0] obs_vec();
    return {u_if.state, u_if.pwr_ack, u_if.clk_en, u_if.iso_en, u_if.sw_en,
            u_if.ret_save, u_if.ret_restore};
  endfunction

  initial begin
    int n;
`ifdef PD_RETENTION_EN
    dn_tab = '{{4'd1, 6'b000100}, {4'd2, 6'b001100}, {4'd2, 6'b001100},
               {4'd3, 6'b001110}, {4'd4, 6'b001000}, {4'd5, 6'b001000}};
    up_tab = '{{4'd6, 6'b001100}, {4'd6, 6'b001100}, {4'd6, 6'b001100},
               {4'd6, 6'b001100}, {4'd7, 6'b001101}, {4'd8, 6'b000100},
               {4'd8, 6'b000100}, {4'd0, 6'b110100}};
`else
    dn_tab = '{{4'd1, 6'b000100}, {4'd2, 6'b001100}, {4'd2, 6'b001100},
               {4'd4, 6'b001000}, {4'd5, 6'b001000}};
    up_tab = '{{4'd6, 6'b001100}, {4'd6, 6'b001100}, {4'd6, 6'b001100},
               {4'd6, 6'b001100}, {4'd8, 6'b000100}, {4'd8, 6'b000100},
               {4'd0, 6'b110100}};
`endif
    u_if.pwr_req = 1'b1;

    // reset
    tick();
    tick();
    rst = 1'b0;
    check_val("rst_outs", 32'(obs_vec()), 32'({4'd0, 6'b110100}));
    check_val("rst_err", 32'(u_if.err), 32'd0);
    check_val("rst_off", u_if.off_cycles, 32'd0);
    check_val("rst_wake", 32'(u_if.wake_cnt), 32'd0);

    // power-down, then three cycles parked in OFF
    u_if.pwr_req = 1'b0;
    for (int k = 0; k < DN_N; k++) begin
      tick();
      check_val($sformatf("dn_e%0d", k), 32'(obs_vec()), 32'(dn_tab[k]));
    end
    tick();
    tick();
    tick();
    check_val("off_park", u_if.off_cycles, 32'd3);

    // power-up; E0 is still an OFF edge
    u_if.pwr_req = 1'b1;
    for (int k = 0; k < UP_N; k++) begin
      tick();
      check_val($sformatf("up_e%0d", k), 32'(obs_vec()), 32'(up_tab[k]));
    end
    check_val("up_wake", 32'(u_if.wake_cnt), 32'd1);
    check_val("up_off", u_if.off_cycles, 32'd4);
    check_val("up_err", 32'(u_if.err), 32'd0);

    // power-good never arrives during power-up
    u_if.pwr_req = 1'b0;
    wait_state(4'd5, 20, "to_down");
    sw_force = 1'b1;
    sw_val   = 1'b0;
    u_if.pwr_req = 1'b1;
    tick();
    n = 0;
    while (u_if.state == 4'd6 && n < 200) begin
      n++;
      tick();
    end
    check_val("to_onsw_cycles", 32'(n), 32'd64);
    check_val("to_next", 32'(u_if.state), (RET != 0) ? 32'd7 : 32'd8);
    check_val("to_err", 32'(u_if.err), 32'd1);
    sw_force = 1'b0;
    wait_state(4'd0, 20, "to_on");
    u_if.pwr_req = 1'b0;
    wait_state(4'd5, 30, "to_down2");
    check_val("to_err_off", 32'(u_if.err), 32'd1);
    u_if.pwr_req = 1'b1;
    wait_state(4'd0, 30, "to_up2");
    check_val("to_err_on", 32'(u_if.err), 32'd1);
    check_val("to_wake", 32'(u_if.wake_cnt), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("to_err_rst", 32'(u_if.err), 32'd0);

    // request toggles while in OFF_ISO are ignored until OFF
    u_if.pwr_req = 1'b0;
    tick();
    tick();
    check_val("mid_iso", 32'(u_if.state), 32'd2);
    u_if.pwr_req = 1'b1;
    tick();
    check_val("mid_hold", 32'(u_if.state), 32'd2);
    u_if.pwr_req = 1'b0;
    #1;
    u_if.pwr_req = 1'b1;
    for (int k = 3; k < DN_N; k++) begin
      tick();
      check_val($sformatf("mid_e%0d", k), 32'(obs_vec()), 32'(dn_tab[k]));
    end
    tick();
    check_val("mid_rev", 32'(u_if.state), 32'd6);
    check_val("mid_off", u_if.off_cycles, 32'd1);
    wait_state(4'd0, 30, "mid_on");
    check_val("mid_wake", 32'(u_if.wake_cnt), 32'd1);

    // rail never collapses during power-down, then reset while in ON_SW
    sw_force = 1'b1;
    sw_val   = 1'b1;
    u_if.pwr_req = 1'b0;
    wait_state(4'd4, 20, "sw_offsw");
    n = 0;
    while (u_if.state == 4'd4 && n < 200) begin
      n++;
      tick();
    end
    check_val("sw_offsw_cycles", 32'(n), 32'd64);
    check_val("sw_off", 32'(u_if.state), 32'd5);
    check_val("sw_err", 32'(u_if.err), 32'd1);
    sw_force = 1'b0;
    u_if.pwr_req = 1'b1;
    tick();
    check_val("rm_onsw", 32'(u_if.state), 32'd6);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rm_outs", 32'(obs_vec()), 32'({4'd0, 6'b110100}));
    check_val("rm_err", 32'(u_if.err), 32'd0);
    check_val("rm_off", u_if.off_cycles, 32'd0);
    check_val("rm_wake", 32'(u_if.wake_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
